lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: request handshake from the execute stage.
REQ-006 SHALL have ports in_is_store input 1, in_func3 input 3, in_addr input ADDR_W, in_wdata input 32, in_rd input 5 (destination tag passed through).
REQ-007 SHALL have ports mem_req_valid output 1 and mem_req_ready input 1: data-memory request handshake.
REQ-008 SHALL have request payload mem_req_wen output 1, mem_req_addr output ADDR_W (word-aligned), mem_req_wdata output 32, mem_req_wmask output 4.
REQ-009 SHALL have ports mem_rsp_valid input 1, mem_rsp_rdata input 32, mem_rsp_err input 1.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1: result handshake to write-back.
REQ-011 SHALL have result payload out_rdata output 32, out_rd output 5, out_err output 1.

Function
REQ-012 SHALL implement FSM IDLE, REQ, WAIT, RESP; in_ready=1 only in IDLE and not during rst.
REQ-013 SHALL capture in_* on in_valid&&in_ready and move IDLE->REQ, or IDLE->RESP with out_err=1 when misaligned or func3 illegal.
REQ-014 Loads: func3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW; any other func3 is illegal.
REQ-015 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; byte never misaligned; misaligned requests issue no memory access.
REQ-016 In REQ: mem_req_valid=1 with payload stable until mem_req_ready; on handshake go to WAIT.
REQ-017 mem_rsp_valid in any state other than WAIT SHALL be ignored; the response arrives at the earliest one cycle after the request handshake.
REQ-018 In WAIT: on mem_rsp_valid, register the result and out_err=mem_rsp_err, then go to RESP.
REQ-019 Load data: select the lane by addr[1:0] (byte) or addr[1] (half); sign-extend for LB/LH and zero-extend for LBU/LHU; LW unchanged.
REQ-020 Store: wmask=0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), 1111 (SW); wdata shifted left by 8*addr[1:0].
REQ-021 Stores SHALL wait for the mem_rsp write acknowledgement; out_rdata=0 for stores and for errors.
REQ-022 mem_req_addr={addr[ADDR_W-1:2],2'b00}; mem_req_wen=in_is_store.
REQ-023 In RESP: out_valid=1 with payload stable until out_ready; on handshake go to IDLE. No new request is accepted in the same cycle.
REQ-024 Minimum latency with zero wait states: accept at cycle 0, out_valid at cycle 3; an error request reaches out_valid at cycle 1.
REQ-025 Exactly one transaction SHALL be in flight; no buffering beyond the single captured request.

Reset
REQ-026 On rst: state=IDLE; mem_req_valid, out_valid, out_err=0; out_rdata, out_rd and captured registers=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction; a late mem_rsp_valid after reset SHALL be ignored.

Structure
REQ-028 Package lsu_pkg SHALL hold the state enum, the func3 load/store constants and the mask constants.
REQ-029 One combinational sub-module, lsu_align, SHALL perform load extraction/extension and store lane shift/mask generation.

Verification
REQ-030 LB at addr 0x103 with rdata 0x80FF_1234 -> out_rdata 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-031 SH at 0x202 with wdata 0x0000_ABCD -> mem addr 0x200, wmask 1100, wdata 0xABCD_0000; out_rdata 0.
REQ-032 LW at 0x101 -> no mem_req_valid; out_valid the next cycle with out_err=1.
REQ-033 mem_req_ready low 3 cycles and out_ready low 2 cycles -> request and result payloads held stable; in_ready stays 0.
REQ-034 rst pulsed in WAIT, then mem_rsp_valid -> IDLE, no out_valid, in_ready=1 the following cycle.
REQ-035 mem_rsp_err=1 on a LW -> out_err=1, out_rdata 0, out_rd equal to the captured tag.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, func3 codes, byte-lane masks and request classification helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Fields of the accepted request still needed after the memory request is issued.
   typedef struct packed {
      logic       is_store;
      logic [2:0] func3;
      logic [1:0] off;
   } cap_t;

   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request, data-memory and write-back handshakes of the LSU in one bundle.
interface lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic              in_is_store;
   logic [2:0]        in_func3;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_wdata;
   logic [4:0]        in_rd;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_wen;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [3:0]        mem_req_wmask;

   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_rdata;
   logic              mem_rsp_err;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_rdata;
   logic [4:0]        out_rd;
   logic              out_err;

   modport slave (
      input  in_valid, in_is_store, in_func3, in_addr, in_wdata, in_rd,
      output in_ready,
      output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
      output out_valid, out_rdata, out_rd, out_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_is_store, in_func3, in_addr, in_wdata, in_rd,
      input  in_ready,
      input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
      input  out_valid, out_rdata, out_rd, out_err,
      output out_ready
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store shift/mask and load extract/extend.
// Latency: purely combinational; no handshake, no backpressure.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_func3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_wmask,
   output logic [31:0] st_wdata_sh,
   input  logic [2:0]  ld_func3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);
   logic [31:0] byte_sel;
   logic [31:0] half_sel;

   always_comb begin
      st_wdata_sh = st_wdata << {st_off, 3'b000};
      case (st_func3)
         F3_B:    st_wmask = MASK_B << st_off;
         F3_H:    st_wmask = MASK_H << st_off;
         F3_W:    st_wmask = MASK_W;
         default: st_wmask = 4'b0000;
      endcase
   end

   // Halves are selected by addr[1] alone; bytes by the full offset.
   always_comb begin
      byte_sel = ld_rdata >> {ld_off, 3'b000};
      half_sel = ld_rdata >> {ld_off[1], 4'b0000};
      case (ld_func3)
         F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel[7:0]};
         F3_BU:   ld_data = {24'd0, byte_sel[7:0]};
         F3_H:    ld_data = {{16{half_sel[15]}}, half_sel[15:0]};
         F3_HU:   ld_data = {16'd0, half_sel[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between execute, data memory and write-back.
// Latency: 3 cycles accept-to-result with zero wait states, 1 cycle for rejected requests; holds every payload while the far side stalls.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);
   state_t      state;
   cap_t        cap;
   logic        bad;
   logic [3:0]  wmask_n;
   logic [DATA_W-1:0] wdata_n;
   logic [DATA_W-1:0] ld_data;

   lsu_align u_align (
      .st_func3    (bus.in_func3),
      .st_off      (bus.in_addr[1:0]),
      .st_wdata    (bus.in_wdata),
      .st_wmask    (wmask_n),
      .st_wdata_sh (wdata_n),
      .ld_func3    (cap.func3),
      .ld_off      (cap.off),
      .ld_rdata    (bus.mem_rsp_rdata),
      .ld_data     (ld_data)
   );

   assign bad          = !f3_legal(bus.in_is_store, bus.in_func3) ||
                         misaligned(bus.in_func3, bus.in_addr[1:0]);
   assign bus.in_ready = (state == ST_IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         cap               <= '0;
         bus.mem_req_valid <= 1'b0;
         bus.mem_req_wen   <= 1'b0;
         bus.mem_req_addr  <= '0;
         bus.mem_req_wdata <= '0;
         bus.mem_req_wmask <= 4'b0000;
         bus.out_valid     <= 1'b0;
         bus.out_err       <= 1'b0;
         bus.out_rdata     <= '0;
         bus.out_rd        <= 5'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  cap        <= '{is_store: bus.in_is_store, func3: bus.in_func3,
                                  off: bus.in_addr[1:0]};
                  bus.out_rd    <= bus.in_rd;
                  bus.out_rdata <= '0;
                  if (bad) begin
                     bus.out_err   <= 1'b1;
                     bus.out_valid <= 1'b1;
                     state         <= ST_RESP;
                  end else begin
                     bus.out_err       <= 1'b0;
                     bus.mem_req_valid <= 1'b1;
                     bus.mem_req_wen   <= bus.in_is_store;
                     bus.mem_req_addr  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
                     bus.mem_req_wdata <= bus.in_is_store ? wdata_n : '0;
                     bus.mem_req_wmask <= bus.in_is_store ? wmask_n : 4'b0000;
                     state             <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (bus.mem_req_ready) begin
                  bus.mem_req_valid <= 1'b0;
                  state             <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Stores and faulted accesses report zero data.
               if (bus.mem_rsp_valid) begin
                  bus.out_valid <= 1'b1;
                  bus.out_err   <= bus.mem_rsp_err;
                  bus.out_rdata <= (bus.mem_rsp_err || cap.is_store) ? '0 : ld_data;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed checks of lsu against a lane-arithmetic reference model.
module tb_lsu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction; entered and left on a falling edge.
   task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input bit rerr,
                        input int req_stall, input int rsp_dly, input int out_stall);
      int          size;
      int          off;
      bit          legal;
      bit          bad;
      logic [31:0] v;
      logic [31:0] e_rdata;
      logic [3:0]  e_mask;
      logic [31:0] e_wdata;
      bit          e_err;

      off   = int'(addr % 4);
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
      bad   = !legal || ((addr % size) != 0);
      e_mask  = 4'(((1 << size) - 1) << off);
      e_wdata = wd << (8 * off);
      v = rdata >> (8 * off);
      if (size < 4) begin
         v = v & ((1 << (8 * size)) - 1);
         if (!f3[2] && v >= (1 << (8 * size - 1)))
            v = v - (1 << (8 * size));
      end
      e_err   = bad || rerr;
      e_rdata = (bad || rerr || st) ? 32'd0 : v;

      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid    = 1'b1;
      bus.in_is_store = st;
      bus.in_func3    = f3;
      bus.in_addr     = addr;
      bus.in_wdata    = wd;
      bus.in_rd       = rd;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_addr  = $urandom;
      bus.in_wdata = $urandom;
      bus.in_func3 = 3'($urandom);
      bus.in_rd    = 5'($urandom);
      @(negedge clk);
      if (bad) begin
         chk("no_mem_req", 32'(bus.mem_req_valid), 32'd0);
      end else begin
         for (int i = 0; i <= req_stall; i++) begin
            chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("req_addr", bus.mem_req_addr, addr & ~32'd3);
            chk("req_wen", 32'(bus.mem_req_wen), 32'(st));
            if (st) begin
               chk("req_wmask", 32'(bus.mem_req_wmask), 32'(e_mask));
               chk("req_wdata", bus.mem_req_wdata, e_wdata);
            end
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            bus.mem_req_ready = (i == req_stall);
            bus.mem_rsp_valid = (i == 0 && req_stall > 0);
            bus.mem_rsp_rdata = $urandom;
            bus.mem_rsp_err   = 1'b1;
            @(negedge clk);
         end
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b0;
         for (int j = 0; j < rsp_dly; j++) begin
            chk("wait_no_out", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
         end
         chk("req_dropped", 32'(bus.mem_req_valid), 32'd0);
         chk("wait_no_out", 32'(bus.out_valid), 32'd0);
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_rdata = rdata;
         bus.mem_rsp_err   = rerr;
         @(negedge clk);
         bus.mem_rsp_valid = 1'b0;
      end
      for (int i = 0; i <= out_stall; i++) begin
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("out_err", 32'(bus.out_err), 32'(e_err));
         chk("out_rdata", bus.out_rdata, e_rdata);
         chk("out_rd", 32'(bus.out_rd), 32'(rd));
         chk("in_ready_resp", 32'(bus.in_ready), 32'd0);
         bus.out_ready = (i == out_stall);
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      chk("out_dropped", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] f3;
      bus.in_valid = 1'b0; bus.in_is_store = 1'b0; bus.in_func3 = 3'd0;
      bus.in_addr = 32'd0; bus.in_wdata = 32'd0; bus.in_rd = 5'd0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = 32'd0; bus.mem_rsp_err = 1'b0; bus.out_ready = 1'b0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_out_rdata", bus.out_rdata, 32'd0);
      chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      do_op(0, 3'b000, 32'h103, 32'h0, 5'd3, 32'h80FF_1234, 0, 0, 0, 0);
      do_op(0, 3'b100, 32'h103, 32'h0, 5'd4, 32'h80FF_1234, 0, 0, 0, 0);
      do_op(1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd5, 32'h1111_2222, 0, 0, 0, 0);
      do_op(0, 3'b010, 32'h101, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);
      do_op(0, 3'b010, 32'h400, 32'h0, 5'd7, 32'hDEAD_BEEF, 0, 3, 0, 2);
      do_op(0, 3'b010, 32'h404, 32'h0, 5'd9, 32'hCAFE_F00D, 1, 0, 1, 0);
      do_op(1, 3'b011, 32'h500, 32'h1234, 5'd10, 32'h0, 0, 0, 0, 0);

      // Reset while waiting for the memory response
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.in_is_store = 1'b0; bus.in_func3 = 3'b010;
      bus.in_addr = 32'h600; bus.in_rd = 5'd11;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h5555_AAAA; bus.mem_rsp_err = 1'b0;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      chk("rstw_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstw_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rstw_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk("rstw_out_valid2", 32'(bus.out_valid), 32'd0);

      // Randomized traffic, biased toward legal encodings
      for (int n = 0; n < 60; n++) begin
         bit st;
         st = 1'($urandom);
         if ($urandom_range(0, 3) == 0)
            f3 = 3'($urandom);
         else if (st)
            f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         do_op(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
               ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
